// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encrypt/decrypt core with one round step per state and multi-cycle MixColumns
module aes_iter_core #(
  parameter int COLS_PER_CYC = 1,
  parameter int KEY_LAT = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [127:0] din,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, KEYWAIT, INIT, SUB, SHIFT, ADDK, MIX, HOLD} fsm_t;
  fsm_t fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d, key_q, key_d, dout_q, dout_d;
  logic mode_q, mode_d, ok_q, ok_d;
  logic [3:0] rnd_q, rnd_d, kc_q, kc_d;
  logic [2:0] col_q, col_d, col_n;
  logic [127:0] rk [16];
  logic [127:0] sub_v, shf_v, mix_v, add_v, kx;
  logic [31:0] tw;
  logic [7:0] rc;
  logic new_key, fin;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254, which maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = (i == 0) ? r : gm(r, p);
      p = gm(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] mixc(input logic [31:0] w, input logic inv);
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) a[k] = w[31-8*k -: 8];
    c[0] = inv ? 8'h0e : 8'h02;
    c[1] = inv ? 8'h0b : 8'h03;
    c[2] = inv ? 8'h0d : 8'h01;
    c[3] = inv ? 8'h09 : 8'h01;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = gm(a[k], c[0]) ^ gm(a[(k+1)%4], c[1]) ^ gm(a[(k+2)%4], c[2]) ^ gm(a[(k+3)%4], c[3]);
    return r;
  endfunction

  // full AES-128 key expansion from the stored key; slots above 10 are unused
  always_comb begin
    kx = key_q;
    rc = 8'h01;
    tw = '0;
    rk[0] = key_q;
    for (int i = 1; i <= 10; i++) begin
      tw = {sb(kx[23:16]), sb(kx[15:8]), sb(kx[7:0]), sb(kx[31:24])} ^ {rc, 24'h0};
      kx[127:96] = kx[127:96] ^ tw;
      kx[95:64] = kx[95:64] ^ kx[127:96];
      kx[63:32] = kx[63:32] ^ kx[95:64];
      kx[31:0] = kx[31:0] ^ kx[63:32];
      rc = xt(rc);
      rk[i] = kx;
    end
    for (int i = 11; i < 16; i++) rk[i] = '0;
  end

  // one-step round transforms of the working block, direction chosen by mode
  always_comb begin
    sub_v = blk_q;
    shf_v = blk_q;
    mix_v = blk_q;
    for (int n = 0; n < 16; n++) begin
      sub_v[127-8*n -: 8] = mode_q ? isb(blk_q[127-8*n -: 8]) : sb(blk_q[127-8*n -: 8]);
      shf_v[127-8*n -: 8] = blk_q[127-8*(4*(((n/4) + (mode_q ? 4-(n%4) : n%4)) % 4) + n%4) -: 8];
    end
    for (int c = 0; c < 4; c++)
      if (c >= int'(col_q) && c < int'(col_q) + COLS_PER_CYC) mix_v[127-32*c -: 32] = mixc(blk_q[127-32*c -: 32], mode_q);
  end

  assign add_v = blk_q ^ rk[rnd_q];
  assign col_n = col_q + 3'(COLS_PER_CYC);
  assign in_ready = (fsm_q == IDLE) && RESET_N;
  assign out_valid = fsm_q == HOLD;
  assign busy = fsm_q != IDLE;
  assign dout = dout_q;

  // sequencing of key settle, rounds and result hold; flush overrides everything
  always_comb begin
    fsm_d = fsm_q;
    blk_d = blk_q;
    key_d = key_q;
    dout_d = dout_q;
    mode_d = mode_q;
    ok_d = ok_q;
    rnd_d = rnd_q;
    kc_d = kc_q;
    col_d = col_q;
    new_key = !ok_q || key != key_q;
    fin = mode_q ? rnd_q == 4'd0 : rnd_q == 4'd10;
    case (fsm_q)
      IDLE: if (in_valid && in_ready) begin
        mode_d = mode;
        blk_d = din;
        key_d = key;
        ok_d = !(new_key && KEY_LAT != 0);
        kc_d = 4'(KEY_LAT - 1);
        fsm_d = (new_key && KEY_LAT != 0) ? KEYWAIT : INIT;
      end
      KEYWAIT: begin
        kc_d = kc_q - 4'd1;
        ok_d = kc_q == 4'd0;
        fsm_d = kc_q == 4'd0 ? INIT : KEYWAIT;
      end
      INIT: begin
        blk_d = blk_q ^ (mode_q ? rk[10] : rk[0]);
        rnd_d = mode_q ? 4'd9 : 4'd1;
        fsm_d = mode_q ? SHIFT : SUB;
      end
      SUB: begin
        blk_d = sub_v;
        fsm_d = mode_q ? ADDK : SHIFT;
      end
      SHIFT: begin
        blk_d = shf_v;
        fsm_d = mode_q ? SUB : (rnd_q == 4'd10 ? ADDK : MIX);
      end
      MIX: begin
        blk_d = mix_v;
        col_d = col_n[2] ? 3'd0 : col_n;
        rnd_d = (col_n[2] && mode_q) ? rnd_q - 4'd1 : rnd_q;
        fsm_d = !col_n[2] ? MIX : (mode_q ? SHIFT : ADDK);
      end
      ADDK: begin
        blk_d = add_v;
        dout_d = fin ? add_v : dout_q;
        rnd_d = (fin || mode_q) ? rnd_q : rnd_q + 4'd1;
        fsm_d = fin ? HOLD : (mode_q ? MIX : SUB);
      end
      HOLD: fsm_d = out_ready ? IDLE : HOLD;
      default: fsm_d = IDLE;
    endcase
    if (flush) begin
      fsm_d = IDLE;
      key_d = key_q;
      ok_d = ok_q;
      dout_d = dout_q;
      col_d = '0;
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      key_q <= '0;
      dout_q <= '0;
      mode_q <= 1'b0;
      ok_q <= 1'b0;
      rnd_q <= '0;
      kc_q <= '0;
      col_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      key_q <= key_d;
      dout_q <= dout_d;
      mode_q <= mode_d;
      ok_q <= ok_d;
      rnd_q <= rnd_d;
      kc_q <= kc_d;
      col_q <= col_d;
    end
endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYC, default 1, giving the number of state columns mixed per cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have parameter KEY_LAT, default 2, giving the key-schedule settle time in cycles; legal values are 0 to 15.
REQ-003 Port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: a job is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts a job.
REQ-007 Port mode, input, 1 bit: 0 encrypts, 1 decrypts; sampled on accept.
REQ-008 Port key, input, 128 bits: the AES-128 cipher key; sampled on accept.
REQ-009 Port din, input, 128 bits: the input block; byte 0 is [127:120], column c is bits [127-32c -: 32].
REQ-010 Port flush, input, 1 bit: synchronous abort.
REQ-011 Port out_valid, output, 1 bit: dout holds a result.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port dout, output, 128 bits: the result block, in the same byte order as din.
REQ-014 Port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, KEYWAIT, INIT, SUB, SHIFT, ADDK, MIX, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; a job is accepted on a rising edge with in_valid=1 and in_ready=1, and the block latches mode, key and din at that edge.
REQ-017 The block SHALL keep a stored key and a key_ok flag; on accept, if key_ok=0 or the key differs from the stored key, the FSM goes to KEYWAIT for KEY_LAT cycles, otherwise it goes directly to INIT (KEYWAIT is also skipped when KEY_LAT=0).
REQ-018 INIT SHALL take 1 cycle: state = din XOR round key 0 when encrypting, or XOR round key 10 when decrypting.
REQ-019 Each encrypt round r = 1..10 SHALL run SUB, SHIFT, MIX (rounds 1..9 only), then ADDK with round key r.
REQ-020 Each decrypt round, for round-key indices 9..0, SHALL run inverse SHIFT, inverse SUB, ADDK with that round key, then inverse MIX; inverse MIX is omitted after the ADDK with round key 0.
REQ-021 SUB, SHIFT and ADDK SHALL take 1 cycle each; MIX SHALL take M = 4/COLS_PER_CYC cycles, processing columns in ascending order COLS_PER_CYC at a time.
REQ-022 The round counter SHALL be 4 bits; the final round is detected at count 10 (encrypt) or 0 (decrypt), with no wrap.
REQ-023 Latency from the accept edge to the out_valid rise SHALL be L = K + 1 + 9*(3+M) + 3, where K = KEY_LAT if KEYWAIT is entered, else 0.
REQ-024 In HOLD, out_valid=1 and dout SHALL stay stable until a rising edge with out_ready=1, after which the FSM returns to IDLE and out_valid falls on that same edge.
REQ-025 A new job SHALL NOT be accepted on the edge that releases HOLD; in_ready rises the following cycle.
REQ-026 flush=1 SHALL force IDLE on the next edge from any state, clear out_valid, discard the job, and keep the stored key and key_ok unchanged.
REQ-027 flush SHALL have priority over both accept and the out_ready release when they coincide.
REQ-028 in_valid and out_ready SHALL be ignored in every state other than IDLE and HOLD respectively.
REQ-029 dout SHALL update only on entry to HOLD; at all other times it holds its last value.

Reset
REQ-030 RESET_N=0 SHALL immediately set the FSM to IDLE, clear key_ok, out_valid, busy and the round counter, and set dout, the state register and the stored key to 0, regardless of any operation in progress.
REQ-031 in_ready SHALL be 0 while RESET_N=0 and SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 With COLS_PER_CYC=4, KEY_LAT=2, mode=0, key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff: dout = 69c4e0d86a7b0430d8cdb78070b4c55a, and out_valid rises exactly 42 cycles after accept.
REQ-033 Same key, mode=1, din 69c4e0d86a7b0430d8cdb78070b4c55a, issued back-to-back: dout = 00112233445566778899aabbccddeeff, and out_valid rises after 40 cycles because KEYWAIT is skipped.
REQ-034 With COLS_PER_CYC=1, KEY_LAT=2, the vector of REQ-032 on a fresh key: same dout, and out_valid rises after 69 cycles.
REQ-035 Hold out_ready=0 for 20 cycles in HOLD: out_valid=1 and dout stay constant throughout, and in_ready stays 0.
REQ-036 Assert flush 10 cycles after accept, then resubmit with the same key: the first job produces no output, and the second result arrives after 40 cycles (key retained).
REQ-037 Pull RESET_N low asynchronously mid-round: out_valid, busy and dout are 0 with no clock edge, and the next job with the same key takes 42 cycles (key_ok cleared).
